// File: rtl/alu_cmd_sequencer.sv
// Issue stage for n_bit_alu: queues {op, a, b} commands, drives registered ALU inputs one command
// at a time and returns captured results in order. Optional counters under `ALU_SEQ_STATS_EN.
module alu_cmd_sequencer #(
    parameter int n     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [n-1:0] cmd_a,
    input  logic [n-1:0] cmd_b,
    output logic [n-1:0] alu_operand1,
    output logic [n-1:0] alu_operand2,
    output logic [2:0]   alu_control,
    input  logic [n-1:0] alu_result,
    input  logic         alu_zero,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_result,
    output logic         rsp_zero,
    output logic [2:0]   rsp_op,
    output logic         busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]  stat_ops,
    output logic [15:0]  stat_zero
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [2:0]   op;
        logic [n-1:0] a;
        logic [n-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } state_t;

    cmd_t         mem [DEPTH];
    cmd_t         head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    state_t        state;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = mem[rd_ptr];
    // A new command issues when idle, or straight off a response handshake.
    assign pop       = !empty && ((state == IDLE) || (state == WAIT && rsp_ready));
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_control  <= 3'b000;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_op       <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_operand1 <= head.a;
                        alu_operand2 <= head.b;
                        alu_control  <= head.op;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_op     <= alu_control;
                    rsp_valid  <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (pop) begin
                            alu_operand1 <= head.a;
                            alu_operand2 <= head.b;
                            alu_control  <= head.op;
                            state        <= EXEC;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops_q;
    logic [15:0] stat_zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q  <= '0;
            stat_zero_q <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
            if (rsp_zero && stat_zero_q != 16'hFFFF) stat_zero_q <= stat_zero_q + 16'd1;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_zero = stat_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural ALU; responses checked against an expected queue.
module tb_alu_cmd_sequencer;

    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic [N-1:0] alu_operand1;
    logic [N-1:0] alu_operand2;
    logic [2:0]   alu_control;
    logic [N-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic [2:0]   rsp_op;
    logic         busy;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0]  stat_ops;
    logic [15:0]  stat_zero;
`endif

    alu_cmd_sequencer #(.n(N), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_operand1 (alu_operand1),
        .alu_operand2 (alu_operand2),
        .alu_control  (alu_control),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .rsp_op       (rsp_op),
        .busy         (busy)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_ops     (stat_ops),
        .stat_zero    (stat_zero)
`endif
    );

    // ---------------- behavioural ALU ----------------
    function automatic logic [N-1:0] alu_model(input logic [2:0] op, input logic [N-1:0] a,
                                               input logic [N-1:0] b);
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return ~(a | b);
            3'b110:  return (a < b) ? N'(1) : N'(0);
            default: return a << b[4:0];
        endcase
    endfunction

    assign alu_result = alu_model(alu_control, alu_operand1, alu_operand2);
    assign alu_zero   = (alu_result == '0);

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [N+3:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int rsp_count = 0;
    bit rand_rdy = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N+3:0] pack_rsp(input logic [2:0] op, input logic [N-1:0] r,
                                              input logic z);
        return {op, r, z};
    endfunction

    // A valid response must always match the queue head, which also covers stability while stalled.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got op=%0d result=%0h with nothing outstanding",
                         rsp_op, rsp_result);
            end else begin
                check("rsp", 64'({rsp_op, rsp_result, rsp_zero}), 64'(exp_q[0]));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    rsp_count++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks ----------------
    task automatic try_cmd(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N+3:0] exp, output bit ok);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(negedge clk);
        ok = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (ok) exp_q.push_back(exp);
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N+3:0] exp);
        bit ok;
        ok = 0;
        for (int c = 0; c < 100 && !ok; c++) try_cmd(op, a, b, exp, ok);
        if (!ok) check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        r = alu_model(op, a, b);
        send_cmd(op, a, b, pack_rsp(op, r, r == '0));
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
        end
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] exp_result;
        logic         exp_zero;
    } vec_t;

    vec_t vec[10];

    initial begin
        bit ok;
        int accepted;
        int cnt0;

        vec[0] = '{3'b000, 32'd15, 32'd12, 32'd27, 1'b0};
        vec[1] = '{3'b001, 32'd12, 32'd12, 32'd0, 1'b1};
        vec[2] = '{3'b000, 32'd15, 32'd12, 32'd27, 1'b0};
        vec[3] = '{3'b001, 32'd15, 32'd12, 32'd3, 1'b0};
        vec[4] = '{3'b010, 32'd15, 32'd12, 32'd12, 1'b0};
        vec[5] = '{3'b011, 32'd15, 32'd12, 32'd15, 1'b0};
        vec[6] = '{3'b100, 32'd15, 32'd12, 32'd3, 1'b0};
        vec[7] = '{3'b101, 32'd15, 32'd12, 32'hFFFF_FFF0, 1'b0};
        vec[8] = '{3'b110, 32'd15, 32'd12, 32'd0, 1'b1};
        vec[9] = '{3'b111, 32'd15, 32'd12, 32'h0000_F000, 1'b0};

        // reset block
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        rsp_ready = 1'b1;
        #2;
        check("reset_cmd_ready", 64'(cmd_ready), 64'(1));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_alu_control", 64'(alu_control), 64'(0));
        check("reset_alu_operand1", 64'(alu_operand1), 64'(0));
        check("reset_rsp_result", 64'(rsp_result), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single commands: latency and field checks
        for (int i = 0; i < 2; i++) begin
            try_cmd(vec[i].op, vec[i].a, vec[i].b,
                    pack_rsp(vec[i].op, vec[i].exp_result, vec[i].exp_zero), ok);
            check("single_accept", 64'(ok), 64'(1));
            check("lat_rsp_valid_k", 64'(rsp_valid), 64'(0));
            @(posedge clk);
            #1;
            check("lat_rsp_valid_k1", 64'(rsp_valid), 64'(0));
            check("issue_control", 64'(alu_control), 64'(vec[i].op));
            check("issue_operand1", 64'(alu_operand1), 64'(vec[i].a));
            check("issue_operand2", 64'(alu_operand2), 64'(vec[i].b));
            @(posedge clk);
            #1;
            check("lat_rsp_valid_k2", 64'(rsp_valid), 64'(1));
            check("single_result", 64'(rsp_result), 64'(vec[i].exp_result));
            check("single_zero", 64'(rsp_zero), 64'(vec[i].exp_zero));
            check("single_op", 64'(rsp_op), 64'(vec[i].op));
            @(posedge clk);
            #1;
            check("single_done_valid", 64'(rsp_valid), 64'(0));
            check("single_done_busy", 64'(busy), 64'(0));
        end
`ifdef ALU_SEQ_STATS_EN
        check("stat_ops_two", 64'(stat_ops), 64'(2));
        check("stat_zero_one", 64'(stat_zero), 64'(1));
`endif

        // stalled response: capacity is one in flight plus DEPTH queued
        rsp_ready = 1'b0;
        accepted = 0;
        cnt0 = rsp_count;
        for (int i = 0; i < 7; i++) begin
            logic [N-1:0] r;
            r = alu_model(3'(i), N'(100 + i), N'(i));
            try_cmd(3'(i), N'(100 + i), N'(i), pack_rsp(3'(i), r, r == '0), ok);
            if (ok) accepted++;
        end
        check("capacity_accepted", 64'(accepted), 64'(DEPTH + 1));
        check("capacity_cmd_ready", 64'(cmd_ready), 64'(0));
        repeat (4) @(posedge clk);
        #1;
        check("stall_rsp_valid", 64'(rsp_valid), 64'(1));
        check("stall_rsp_result", 64'(rsp_result), 64'(100));
        rsp_ready = 1'b1;
        wait_drain("stall");
        check("stall_rsp_count", 64'(rsp_count - cnt0), 64'(DEPTH + 1));

        // table stream with random backpressure
        cnt0 = rsp_count;
        rand_rdy = 1;
        for (int i = 2; i < 10; i++) begin
            send_cmd(vec[i].op, vec[i].a, vec[i].b,
                     pack_rsp(vec[i].op, vec[i].exp_result, vec[i].exp_zero));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_rdy = 0;
        rsp_ready = 1'b1;
        wait_drain("stream");
        check("stream_rsp_count", 64'(rsp_count - cnt0), 64'(8));

        // reset while EXEC with three commands queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_model(3'(i + 1), N'(40 + i), N'(3));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("pre_reset_exec_control", 64'(alu_control), 64'(2));
        check("pre_reset_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_alu_control", 64'(alu_control), 64'(0));
        check("midreset_alu_operand1", 64'(alu_operand1), 64'(0));
        check("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midreset_cmd_ready", 64'(cmd_ready), 64'(1));
        check("midreset_busy", 64'(busy), 64'(0));
        cnt0 = rsp_count;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_no_rsp", 64'(rsp_count - cnt0), 64'(0));
        check("post_reset_busy", 64'(busy), 64'(0));

`ifdef ALU_SEQ_STATS_EN
        dut.stat_ops_q = 16'hFFFE;
        for (int i = 0; i < 3; i++) send_model(3'b000, N'(i), N'(1));
        wait_drain("sat");
        check("stat_ops_saturate", 64'(stat_ops), 64'(16'hFFFF));
`endif

        // post-run queue sanity: every pushed expectation was consumed
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
